// File: rtl/lbp_histogram_if.sv
// Stream-in / readout-out bundle for lbp_histogram: LBP code input, frame finish,
// and the valid/ready histogram readout with status.
interface lbp_histogram_if #(
    parameter int CNT_W = 14
);
    logic             lbp_valid;
    logic [13:0]      lbp_addr;
    logic [7:0]       lbp_data;
    logic             finish;
    logic             hist_valid;
    logic             hist_ready;
    logic [7:0]       hist_bin;
    logic [CNT_W-1:0] hist_cnt;
    logic             hist_last;
    logic [13:0]      pix_cnt;
    logic             done;
    logic             addr_err;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_cnt, hist_last, pix_cnt, done, addr_err
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_cnt, hist_last, pix_cnt, done, addr_err
    );
endinterface

// File: rtl/lbp_histogram.sv
// 256-bin histogram of LBP codes over one frame, drained bin by bin after finish.
// Optional raster address checking is enabled with `define LBP_HIST_ADDRCHK_EN.
module lbp_histogram #(
    parameter int CNT_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    lbp_histogram_if.slave    bus
);
    localparam logic [1:0]       ST_ACCUM    = 2'd0;
    localparam logic [1:0]       ST_DRAIN    = 2'd1;
    localparam logic [1:0]       ST_DONE     = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [13:0]      PIX_MAX     = '1;
    localparam logic [13:0]      FRAME_CODES = 14'd15876;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_bins [256];
    logic [7:0]       r_rd;
    logic [13:0]      r_pix;

    logic        w_accept;
    logic        w_draining;
    logic        w_hs;
    logic [13:0] w_pix_next;

    assign w_accept   = (r_state == ST_ACCUM) && bus.lbp_valid;
    assign w_draining = (r_state == ST_DRAIN);
    assign w_hs       = w_draining && bus.hist_ready;
    assign w_pix_next = (w_accept && (r_pix != PIX_MAX)) ? r_pix + 14'd1 : r_pix;

    // NOTE: the bin array is built from flops rather than RAM because every bin
    // must clear on reset; a RAM macro could not be cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                r_bins[i] <= '0;
            end
        end else if (w_accept && (r_bins[bus.lbp_data] != CNT_MAX)) begin
            r_bins[bus.lbp_data] <= r_bins[bus.lbp_data] + 1'b1;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ACCUM;
            r_rd    <= 8'd0;
            r_pix   <= 14'd0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    r_pix <= w_pix_next;
                    if (bus.finish) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_hs) begin
                        r_rd <= r_rd + 8'd1;
                        if (r_rd == 8'd255) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: r_state <= ST_DONE;
            endcase
        end
    end

    // Readout fields are forced to zero outside DRAIN so idle buses stay quiet.
    assign bus.hist_valid = w_draining;
    assign bus.hist_bin   = w_draining ? r_rd : 8'd0;
    assign bus.hist_cnt   = w_draining ? r_bins[r_rd] : '0;
    assign bus.hist_last  = w_draining && (r_rd == 8'd255);
    assign bus.pix_cnt    = r_pix;
    assign bus.done       = (r_state == ST_DONE);

`ifdef LBP_HIST_ADDRCHK_EN
    logic [6:0] r_exp_row;
    logic [6:0] r_exp_col;
    logic       r_addr_err;

    // Expected address walks the 126x126 interior even after a mismatch, so a
    // single skipped pixel flags once and then keeps comparing against raster.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp_row  <= 7'd1;
            r_exp_col  <= 7'd1;
            r_addr_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (bus.lbp_addr != {r_exp_row, r_exp_col}) begin
                    r_addr_err <= 1'b1;
                end
                if (r_exp_col == 7'd126) begin
                    r_exp_col <= 7'd1;
                    r_exp_row <= r_exp_row + 7'd1;
                end else begin
                    r_exp_col <= r_exp_col + 7'd1;
                end
            end
            if ((r_state == ST_ACCUM) && bus.finish && (w_pix_next != FRAME_CODES)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign bus.addr_err = r_addr_err;
`else
    assign bus.addr_err = 1'b0;
`endif
endmodule

// File: tb/tb_lbp_histogram.sv
// Directed self-checking bench for lbp_histogram: full-frame histograms, stalled
// drains, saturation with CNT_W=4, mid-drain reset and (when enabled) address checks.
module tb_lbp_histogram;
    logic clk;
    logic reset;

    lbp_histogram_if #(.CNT_W(14)) bus ();
    lbp_histogram_if #(.CNT_W(4))  bus4 ();

    lbp_histogram #(.CNT_W(14)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
    lbp_histogram #(.CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

`ifdef LBP_HIST_ADDRCHK_EN
    localparam bit ADDRCHK = 1'b1;
`else
    localparam bit ADDRCHK = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_bins [256];
    int exp_pix;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) exp_bins[i] = 0;
        exp_pix = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        clear_model();
    endtask

    // One code per call; consecutive calls give back-to-back lbp_valid.
    task automatic send(input logic [7:0] d, input int r, input int c, input logic fin);
        logic [6:0] r7;
        logic [6:0] c7;
        r7 = r[6:0];
        c7 = c[6:0];
        bus.lbp_valid = 1'b1;
        bus.lbp_data  = d;
        bus.lbp_addr  = {r7, c7};
        bus.finish    = fin;
        tick();
        bus.lbp_valid = 1'b0;
        bus.finish    = 1'b0;
        if (exp_bins[d] < 16383) exp_bins[d]++;
        if (exp_pix < 16383) exp_pix++;
    endtask

    // Raster frame of interior codes; mode 0 sends all zeros, mode 1 sends index mod 256.
    task automatic send_frame(input int mode, input int skip_r, input int skip_c);
        int idx;
        logic [31:0] idx32;
        idx = 0;
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                if (!(r == skip_r && c == skip_c)) begin
                    idx32 = idx;
                    send((mode == 0) ? 8'h00 : idx32[7:0], r, c, 1'b0);
                    idx++;
                end
            end
        end
    endtask

    task automatic start_drain();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1. Returns early when rd==stop_at.
    task automatic drain_check(input int mode, input logic exp_err, input int stop_at,
                               input int exp_cycles);
        int   rd;
        int   cyc;
        logic rdy;
        rd  = 0;
        cyc = 0;
        check("drain_pix_cnt", bus.pix_cnt, exp_pix);
        while (rd < 256 && cyc < 2000) begin
            if (rd == stop_at) return;
            check("drain_valid", bus.hist_valid, 1);
            check("drain_bin", bus.hist_bin, rd);
            check("drain_cnt", bus.hist_cnt, exp_bins[rd]);
            check("drain_last", bus.hist_last, rd == 255);
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            bus.hist_ready = rdy;
            tick();
            cyc++;
            if (rdy) rd++;
        end
        bus.hist_ready = 1'b0;
        check("drain_cycles", cyc, exp_cycles);
        check("done_flag", bus.done, 1);
        check("done_valid", bus.hist_valid, 0);
        check("done_bin", bus.hist_bin, 0);
        check("done_cnt", bus.hist_cnt, 0);
        check("done_last", bus.hist_last, 0);
        check("done_addr_err", bus.addr_err, exp_err);
        bus.lbp_valid  = 1'b1;
        bus.lbp_data   = 8'h00;
        bus.finish     = 1'b1;
        bus.hist_ready = 1'b1;
        repeat (3) tick();
        bus.lbp_valid  = 1'b0;
        bus.finish     = 1'b0;
        bus.hist_ready = 1'b0;
        check("done_sticky", bus.done, 1);
        check("done_sticky_valid", bus.hist_valid, 0);
        check("done_pix_frozen", bus.pix_cnt, exp_pix);
    endtask

    initial begin
        logic [7:0] codes10 [10];
        int         rd4;
        int         cyc4;

        reset = 1'b1;
        bus.lbp_valid = 1'b0; bus.lbp_addr = '0; bus.lbp_data = '0;
        bus.finish = 1'b0; bus.hist_ready = 1'b0;
        bus4.lbp_valid = 1'b0; bus4.lbp_addr = '0; bus4.lbp_data = '0;
        bus4.finish = 1'b0; bus4.hist_ready = 1'b0;
        clear_model();
        repeat (2) tick();
        check("rst_valid", bus.hist_valid, 0);
        check("rst_bin", bus.hist_bin, 0);
        check("rst_cnt", bus.hist_cnt, 0);
        check("rst_last", bus.hist_last, 0);
        check("rst_pix", bus.pix_cnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr_err", bus.addr_err, 0);
        reset = 1'b0;
        tick();

        // Frame of all-zero codes: bin 0 collects the whole frame.
        send_frame(0, 0, 0);
        check("zero_frame_pix", bus.pix_cnt, 15876);
        check("zero_frame_valid_accum", bus.hist_valid, 0);
        start_drain();
        drain_check(0, 1'b0, -1, 256);

        // Frame of index mod 256, drained with stalls.
        pulse_reset();
        tick();
        send_frame(1, 0, 0);
        check("mod_frame_bin3_model", exp_bins[3], 63);
        start_drain();
        drain_check(1, 1'b0, -1, 512);

`ifdef LBP_HIST_ADDRCHK_EN
        // Pixel (5,10) missing from the raster.
        pulse_reset();
        tick();
        send_frame(0, 5, 10);
        check("skip_addr_err_accum", bus.addr_err, 1);
        check("skip_pix", bus.pix_cnt, 15875);
        start_drain();
        drain_check(0, 1'b1, -1, 256);

        // Clean raster but finish after only 100 codes.
        pulse_reset();
        tick();
        for (int i = 0; i < 100; i++) send(8'h11, 1 + i / 126, 1 + i % 126, 1'b0);
        check("short_addr_err_before", bus.addr_err, 0);
        start_drain();
        check("short_addr_err_after", bus.addr_err, 1);
        drain_check(0, 1'b1, -1, 256);
`endif

        // Reset pulse while bin 37 is presented.
        pulse_reset();
        tick();
        for (int i = 0; i < 50; i++) send(8'(i * 7), 1 + i / 126, 1 + i % 126, 1'b0);
        start_drain();
        drain_check(0, ADDRCHK, 37, 0);
        check("pre_reset_bin", bus.hist_bin, 37);
        reset = 1'b1;
        #2;
        check("midrst_valid", bus.hist_valid, 0);
        check("midrst_bin", bus.hist_bin, 0);
        check("midrst_cnt", bus.hist_cnt, 0);
        check("midrst_last", bus.hist_last, 0);
        check("midrst_pix", bus.pix_cnt, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_addr_err", bus.addr_err, 0);
        reset = 1'b0;
        clear_model();
        tick();

        // Ten-code frame with repeats; the last code arrives together with finish.
        codes10 = '{8'd3, 8'd3, 8'd3, 8'd0, 8'd255, 8'd255, 8'd17, 8'd17, 8'd17, 8'd200};
        for (int i = 0; i < 10; i++) send(codes10[i], 1, 1 + i, (i == 9) ? 1'b1 : 1'b0);
        check("ten_bin3_model", exp_bins[3], 3);
        drain_check(0, ADDRCHK, -1, 256);

        // Narrow counters saturate at 15.
        pulse_reset();
        tick();
        for (int i = 0; i < 20; i++) begin
            bus4.lbp_valid = 1'b1;
            bus4.lbp_data  = 8'h5A;
            tick();
        end
        bus4.lbp_valid = 1'b0;
        check("sat_pix", bus4.pix_cnt, 20);
        bus4.finish = 1'b1;
        tick();
        bus4.finish = 1'b0;
        rd4  = 0;
        cyc4 = 0;
        bus4.hist_ready = 1'b1;
        while (rd4 < 256 && cyc4 < 400) begin
            if (rd4 == 0 || rd4 == 89 || rd4 == 90 || rd4 == 91 || rd4 == 255) begin
                check("sat_bin", bus4.hist_bin, rd4);
                check("sat_cnt", bus4.hist_cnt, (rd4 == 90) ? 15 : 0);
            end
            tick();
            rd4++;
            cyc4++;
        end
        bus4.hist_ready = 1'b0;
        check("sat_cycles", cyc4, 256);
        check("sat_done", bus4.done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lbp_histogram.md
# lbp_histogram

Downstream consumer of the LBP stage's output stream. It accepts one 8-bit LBP code per `lbp_valid` pulse and accumulates a 256-bin histogram of the codes over one 128x128 frame (126x126 interior codes). On the LBP stage's `finish` level it drains the histogram bin by bin over a valid/ready port, then parks in a done state until reset.

## Interface
- `CNT_W`, default 14: per-bin counter width. 14 holds a full frame (15876).
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `lbp_valid` input 1: one code present this cycle. Back-to-back cycles are legal.
- `lbp_addr` input 14: {row[6:0], col[6:0]} of the code. Used only by the address check.
- `lbp_data` input 8: LBP code, which is the bin index.
- `finish` input 1: level from the LBP stage; the frame is complete.
- `hist_valid` output 1: readout word valid.
- `hist_ready` input 1: downstream accepts the readout word.
- `hist_bin` output 8: bin index of the current readout word.
- `hist_cnt` output CNT_W: count of `hist_bin`.
- `hist_last` output 1: high with `hist_valid` when `hist_bin`==255.
- `pix_cnt` output 14: number of codes accepted this frame. Saturates at 16383.
- `done` output 1: readout complete; sticky until reset.
- `addr_err` output 1: sticky address-sequence error (see Configuration).

## Operation
- States: ACCUM (reset state), DRAIN, DONE.
- ACCUM, when `lbp_valid`=1:
  - `bin[lbp_data]` increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - `pix_cnt` increments by 1, saturating.
  - The read-modify-write completes in one cycle, so back-to-back codes to the same bin each count.
- ACCUM -> DRAIN on any cycle with `finish`=1.
  - If `lbp_valid` is also high that cycle, that code is counted first.
- DRAIN:
  - Read index `rd` starts at 0.
  - `hist_valid`=1, `hist_bin`=`rd`, `hist_cnt`=`bin[rd]`.
  - On `hist_valid & hist_ready`, `rd` increments.
  - A handshake while `rd`==255 moves to DONE.
  - `lbp_valid` is ignored in DRAIN; bins and `pix_cnt` are frozen.
- DONE:
  - `hist_valid`=0 and `done`=1.
  - All inputs are ignored; only reset leaves DONE.
- `hist_bin`/`hist_cnt` are driven from `rd` and the bin array. They stay stable while `hist_valid & !hist_ready`.

## Timing
- Reset values:
  - state=ACCUM, all 256 bins=0, `rd`=0, `pix_cnt`=0.
  - `hist_valid`=0, `hist_bin`=0, `hist_cnt`=0, `hist_last`=0, `done`=0, `addr_err`=0.
  - Outside DRAIN, `hist_bin`/`hist_cnt`/`hist_last` read 0.
- Accumulation latency: a code accepted at edge N is visible in `bin[]` and `pix_cnt` after edge N.
- Drain start: `finish` sampled at edge N puts `hist_valid`=1 in the cycle after edge N; bin 0 is presented first.
- Throughput: with `hist_ready` held high, the drain takes exactly 256 cycles. `done` rises in the cycle after the bin-255 handshake.
- `hist_ready` is sampled only while `hist_valid`=1.
- Reset asserted mid-ACCUM or mid-DRAIN clears everything immediately (asynchronous). The next frame starts in ACCUM.

## Configuration
- Macro `LBP_HIST_ADDRCHK_EN`.
- Defined:
  - An expected-address register starts at {7'd1,7'd1}.
  - On each accepted `lbp_valid`, if `lbp_addr` differs from the expected value, `addr_err` sets (sticky).
  - The expected value then advances raster-style regardless of match: col+1; col 126 -> col 1 and row+1.
  - On entry to DRAIN, `addr_err` also sets if `pix_cnt` != 15876.
- Undefined: no expected-address logic; `addr_err` is tied to 0 and `lbp_addr` is unused.

## Test plan
- All 15876 codes = 8'h00 in raster order, then `finish`:
  - bin 0 reads 15876, bins 1..255 read 0.
  - `pix_cnt`=15876, `hist_last` only on bin 255, `done`=1 after 256 handshakes, `addr_err`=0.
- Code k = index mod 256 over a full frame:
  - bins 0..3 read 63, bins 4..255 read 62.
  - Back-to-back `lbp_valid` with repeated codes loses no counts.
- Drain with `hist_ready` toggling 1,0,0,1:
  - `hist_bin`/`hist_cnt` hold during stalls, every bin appears exactly once in order, `done` is delayed accordingly.
- CNT_W=4, 20 codes of 8'h5A:
  - bin 90 reads 15 (saturated), `pix_cnt`=20.
- `LBP_HIST_ADDRCHK_EN` defined:
  - Frame with pixel (5,10) skipped sets `addr_err`=1 and keeps it through DONE.
  - A clean full frame leaves `addr_err`=0.
  - `finish` after 100 codes sets `addr_err`=1.
- Reset pulse at drain bin 37:
  - All outputs return to reset values.
  - A following 10-code frame drains with only those 10 counts.
